// File: rtl/execute_result_buffer_pkg.sv
// Shared definitions for the execute-stage result buffer.
//  - Register-file index, accuracy and data widths of the execute stage.
//  - Entry layout {accuracy, write_enable, rd, result}.
//  - Saturating counter increment helper.
package execute_result_buffer_pkg;

  localparam int RF_INDEX_WIDTH  = 5;
  localparam int ACCURACY_WIDTH  = 8;
  localparam int EXEC_DATA_WIDTH = 32;
  localparam logic [RF_INDEX_WIDTH-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [ACCURACY_WIDTH-1:0]  accuracy;
    logic                       write_enable;
    logic [RF_INDEX_WIDTH-1:0]  rd;
    logic [EXEC_DATA_WIDTH-1:0] result;
  } erb_entry_t;

  // Increment by one when en is set, sticking at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/execute_result_forward_match.sv
// One forwarding lookup port over the result buffer.
//  entries : raw storage slots
//  head    : slot index of the oldest entry
//  count   : number of valid entries
//  enable  : low forces a miss (flush/reset)
//  index   : register being looked up
//  hit     : a valid entry will write index
//  data    : result of the youngest matching entry, 0 on miss
module execute_result_forward_match
  import execute_result_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  erb_entry_t [DEPTH-1:0]          entries,
  input  logic [PTR_W-1:0]                head,
  input  logic [CNT_W-1:0]                count,
  input  logic                            enable,
  input  logic [RF_INDEX_WIDTH-1:0]       index,
  output logic                            hit,
  output logic [EXEC_DATA_WIDTH-1:0]      data
);

  logic [PTR_W-1:0] slot;

  // Walk oldest -> youngest; later matches overwrite earlier ones so the
  // youngest match is what remains.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if (enable && (CNT_W'(k) < count) && entries[slot].write_enable &&
          (entries[slot].rd == index) && (index != ZERO_REG)) begin
        hit  = 1'b1;
        data = entries[slot].result;
      end
    end
  end

endmodule

// File: rtl/execute_result_buffer.sv
// In-order result FIFO between the ALU (execute) and register writeback.
//  clk/reset          : rising-edge clock, synchronous active-high reset
//  flush              : drop all entries (redirect)
//  in_*               : ALU result push side (valid/ready)
//  wb_*               : head entry to writeback (valid/ready), zero when empty
//  fwd_rs{1,2}_*      : combinational youngest-match lookups for hazard logic
//  retired_count      : saturating count of pops
//  approx_count       : saturating count of pops with accuracy_level != 0
module execute_result_buffer
  import execute_result_buffer_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = EXEC_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                in_rd,
  input  logic                      in_write_enable,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic [7:0]                in_accuracy_level,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [4:0]                wb_rd,
  output logic                      wb_write_enable,
  output logic [DATA_WIDTH-1:0]     wb_result,
  input  logic [4:0]                fwd_rs1_index,
  input  logic [4:0]                fwd_rs2_index,
  output logic                      fwd_rs1_hit,
  output logic [DATA_WIDTH-1:0]     fwd_rs1_data,
  output logic                      fwd_rs2_hit,
  output logic [DATA_WIDTH-1:0]     fwd_rs2_data,
  output logic [31:0]               retired_count,
  output logic [31:0]               approx_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int N_PORTS = 2;

  erb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [31:0]            retired_q, retired_d, approx_q, approx_d;
  erb_entry_t             head_entry;
  logic                   push, pop;

  always_comb begin
    // Ready ignores wb_ready: a full buffer never accepts, even on a pop.
    in_ready   = (count_q < CNT_W'(DEPTH)) & ~flush & ~reset;
    wb_valid   = (count_q != '0) & ~flush & ~reset;
    head_entry = (count_q != '0) ? mem_q[head_q] : '0;
    push       = in_valid & in_ready;
    pop        = wb_valid & wb_ready;

    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    retired_d = retired_q;
    approx_d  = approx_q;

    if (push) begin
      // x0 is tagged non-writing so it is never written back or forwarded.
      mem_d[tail_q] = '{accuracy:     in_accuracy_level,
                        write_enable: in_write_enable & (in_rd != ZERO_REG),
                        rd:           in_rd,
                        result:       in_result};
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d    = head_q + PTR_W'(1);
      retired_d = sat_inc(retired_q, 1'b1);
      approx_d  = sat_inc(approx_q, head_entry.accuracy != '0);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Handshakes are already blocked during flush; only the queue is cleared.
    if (flush) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      retired_q <= '0;
      approx_q  <= '0;
    end else begin
      mem_q     <= mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      retired_q <= retired_d;
      approx_q  <= approx_d;
    end
  end

  assign wb_rd           = head_entry.rd;
  assign wb_write_enable = head_entry.write_enable;
  assign wb_result       = head_entry.result;
  assign retired_count   = retired_q;
  assign approx_count    = approx_q;

  logic [N_PORTS-1:0][4:0]            fwd_index;
  logic [N_PORTS-1:0]                 fwd_hit;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0] fwd_data;

  assign fwd_index = {fwd_rs2_index, fwd_rs1_index};

  for (genvar p = 0; p < N_PORTS; p++) begin : g_fwd
    execute_result_forward_match #(.DEPTH(DEPTH)) u_match (
      .entries (mem_q),
      .head    (head_q),
      .count   (count_q),
      .enable  (~flush & ~reset),
      .index   (fwd_index[p]),
      .hit     (fwd_hit[p]),
      .data    (fwd_data[p])
    );
  end

  assign fwd_rs1_hit  = fwd_hit[0];
  assign fwd_rs1_data = fwd_data[0];
  assign fwd_rs2_hit  = fwd_hit[1];
  assign fwd_rs2_data = fwd_data[1];

endmodule

// File: tb/tb_execute_result_buffer.sv
module tb_execute_result_buffer;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_write_enable;
  logic [4:0]  in_rd, wb_rd, fwd_rs1_index, fwd_rs2_index;
  logic [31:0] in_result, wb_result, fwd_rs1_data, fwd_rs2_data;
  logic [7:0]  in_accuracy_level;
  logic        wb_valid, wb_ready, wb_write_enable, fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] retired_count, approx_count;

  always #5 clk = ~clk;

  execute_result_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_write_enable(in_write_enable), .in_result(in_result),
    .in_accuracy_level(in_accuracy_level),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_write_enable(wb_write_enable), .wb_result(wb_result),
    .fwd_rs1_index(fwd_rs1_index), .fwd_rs2_index(fwd_rs2_index),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs1_data(fwd_rs1_data),
    .fwd_rs2_hit(fwd_rs2_hit), .fwd_rs2_data(fwd_rs2_data),
    .retired_count(retired_count), .approx_count(approx_count)
  );

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] res;
    logic [7:0]  acc;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] m_ret = 0;
  logic [31:0] m_apx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model lookup: {hit, data} of the youngest pending write to idx.
  function automatic logic [32:0] mfwd(input logic [4:0] idx);
    logic [32:0] r = '0;
    foreach (mq[i])
      if (mq[i].we && mq[i].rd == idx && idx != 0) r = {1'b1, mq[i].res};
    return r;
  endfunction

  // Monitor: at each falling edge compare DUT outputs with the scoreboard,
  // then advance the scoreboard with the inputs the next rising edge consumes.
  always @(negedge clk) begin : monitor
    logic        rdy, vld;
    logic [32:0] f1, f2;
    ment_t       e;
    rdy = (mq.size() < 2) && !flush && !reset;
    vld = (mq.size() != 0) && !flush && !reset;
    chk("mon_in_ready", in_ready, rdy);
    chk("mon_wb_valid", wb_valid, vld);
    if (!reset && !flush) begin
      if (mq.size() != 0) begin
        chk("mon_wb_rd", wb_rd, mq[0].rd);
        chk("mon_wb_we", wb_write_enable, mq[0].we);
        chk("mon_wb_result", wb_result, mq[0].res);
      end else begin
        chk("mon_wb_empty", {wb_rd, wb_write_enable, wb_result}, 0);
      end
    end
    chk("mon_retired", retired_count, m_ret);
    chk("mon_approx", approx_count, m_apx);
    f1 = (reset || flush) ? 33'd0 : mfwd(fwd_rs1_index);
    f2 = (reset || flush) ? 33'd0 : mfwd(fwd_rs2_index);
    chk("mon_fwd1_hit", fwd_rs1_hit, f1[32]);
    chk("mon_fwd1_data", fwd_rs1_data, f1[31:0]);
    chk("mon_fwd2_hit", fwd_rs2_hit, f2[32]);
    chk("mon_fwd2_data", fwd_rs2_data, f2[31:0]);

    if (reset) begin
      mq.delete();
      m_ret = 0;
      m_apx = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (vld && wb_ready) begin
        e = mq.pop_front();
        if (m_ret != 32'hFFFF_FFFF) m_ret++;
        if (e.acc != 0 && m_apx != 32'hFFFF_FFFF) m_apx++;
      end
      if (in_valid && rdy) begin
        e.rd  = in_rd;
        e.we  = in_write_enable && (in_rd != 0);
        e.res = in_result;
        e.acc = in_accuracy_level;
        mq.push_back(e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input logic [4:0] rd, input logic we,
                          input logic [31:0] res, input logic [7:0] acc);
    in_valid          = 1'b1;
    in_rd             = rd;
    in_write_enable   = we;
    in_result         = res;
    in_accuracy_level = acc;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rd = '0;
    in_write_enable = 1'b0; in_result = '0; in_accuracy_level = '0;
    wb_ready = 1'b0; fwd_rs1_index = '0; fwd_rs2_index = '0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_retired", retired_count, 0);

    // 1: single push, one-cycle latency
    push_set(5, 1, 9, 0); cyc(); in_valid = 1'b0;
    chk("t1_wb_valid", wb_valid, 1);
    chk("t1_wb_rd", wb_rd, 5);
    chk("t1_wb_result", wb_result, 9);
    chk("t1_in_ready", in_ready, 1);

    // 2: fill, overflow push ignored, drain in order
    push_set(6, 1, 10, 1); cyc();
    chk("t2_full_ready", in_ready, 0);
    push_set(8, 1, 11, 0); cyc(); in_valid = 1'b0;
    chk("t2_still_full", in_ready, 0);
    chk("t2_head", wb_result, 9);
    wb_ready = 1'b1; cyc();
    chk("t2_second", wb_result, 10);
    cyc();
    chk("t2_empty", wb_valid, 0);
    chk("t2_retired", retired_count, 2);
    chk("t2_approx", approx_count, 1);
    wb_ready = 1'b0;

    // 3: youngest-match forwarding and x0 never forwarded
    push_set(7, 1, 3, 0); cyc();
    push_set(7, 1, 6, 0); cyc(); in_valid = 1'b0;
    fwd_rs1_index = 7; fwd_rs2_index = 5; #1;
    chk("t3_rs1_hit", fwd_rs1_hit, 1);
    chk("t3_rs1_data", fwd_rs1_data, 6);
    chk("t3_rs2_hit", fwd_rs2_hit, 0);
    chk("t3_rs2_data", fwd_rs2_data, 0);
    wb_ready = 1'b1; cyc(); cyc(); wb_ready = 1'b0;
    push_set(0, 1, 5, 0); cyc(); in_valid = 1'b0;
    fwd_rs1_index = 0; #1;
    chk("t3_x0_hit", fwd_rs1_hit, 0);
    chk("t3_x0_we", wb_write_enable, 0);
    wb_ready = 1'b1; cyc(); wb_ready = 1'b0;

    // 4: approximate retire counting with overlapped push/pop
    wb_ready = 1'b1;
    push_set(1, 1, 20, 0); cyc();
    push_set(2, 1, 21, 1); cyc();
    push_set(3, 0, 22, 2); cyc(); in_valid = 1'b0;
    cyc();
    chk("t4_retired", retired_count, 8);
    chk("t4_approx", approx_count, 3);

    // 5: flush with full buffer and live handshakes
    wb_ready = 1'b0;
    push_set(3, 1, 30, 5); cyc();
    push_set(4, 1, 31, 5); cyc();
    push_set(9, 1, 32, 0); flush = 1'b1; wb_ready = 1'b1; fwd_rs1_index = 3; #1;
    chk("t5_flush_wb_valid", wb_valid, 0);
    chk("t5_flush_in_ready", in_ready, 0);
    chk("t5_flush_fwd", fwd_rs1_hit, 0);
    cyc(); flush = 1'b0; in_valid = 1'b0; #1;
    chk("t5_post_wb_valid", wb_valid, 0);
    chk("t5_post_in_ready", in_ready, 1);
    chk("t5_post_retired", retired_count, 8);
    chk("t5_post_approx", approx_count, 3);
    chk("t5_post_fwd", fwd_rs1_hit, 0);

    // 6: sustained push+pop at count=1, pointers wrap
    wb_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      push_set(1, 1, 32'(i), 0); cyc();
    end
    in_valid = 1'b0; cyc();
    chk("t6_retired", retired_count, 18);
    chk("t6_empty", wb_valid, 0);

    // 7: reset mid-operation discards entries and clears counters
    wb_ready = 1'b0;
    push_set(2, 1, 40, 3); cyc(); in_valid = 1'b0;
    reset = 1'b1; #1;
    chk("t7_rst_wb_valid", wb_valid, 0);
    chk("t7_rst_in_ready", in_ready, 0);
    cyc(); reset = 1'b0; #1;
    chk("t7_retired", retired_count, 0);
    chk("t7_approx", approx_count, 0);
    chk("t7_wb_valid", wb_valid, 0);
    chk("t7_in_ready", in_ready, 1);

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
